// File: rtl/axi_defines.sv
// Shared constants for the AXI slave memory: response codes, FSM encodings
// and default bus geometry.
package axi_defines;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_MEM_DEPTH  = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word-wide RAM with per-byte write enables and one registered read port.
// Read and write in the same cycle to the same word return the old contents.
module axi_slave_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RAM_AW     = 10
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [RAM_AW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [RAM_AW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  // One byte-wide array per lane keeps byte enables a plain write enable.
  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) mem[waddr] <= wdata[gi*8 +: 8];
      if (re)     q_reg      <= mem[raddr];
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: single-outstanding INCR bursts, independent read and
// write FSMs sharing one byte-enabled RAM.
module axi_slave_mem
  import axi_defines::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF;
  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  wr_state_e           w_state_reg, w_state_next;
  logic [ID_WIDTH-1:0] wid_reg, wid_next;
  logic [IDX_W-1:0]    widx_reg, widx_next;
  logic [7:0]          wlen_reg, wlen_next, wcnt_reg, wcnt_next;
  logic                werr_reg, werr_next;
  logic                w_in_range, w_last_beat, ram_we;

  rd_state_e           r_state_reg, r_state_next;
  logic [ID_WIDTH-1:0] rid_reg, rid_next;
  logic [IDX_W-1:0]    ridx_reg, ridx_next, ram_raddr_idx;
  logic [7:0]          rlen_reg, rlen_next, rcnt_reg, rcnt_next;
  logic                r_in_range, ram_re;
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      wid_reg     <= '0;
      widx_reg    <= '0;
      wlen_reg    <= '0;
      wcnt_reg    <= '0;
      werr_reg    <= 1'b0;
      r_state_reg <= R_IDLE;
      rid_reg     <= '0;
      ridx_reg    <= '0;
      rlen_reg    <= '0;
      rcnt_reg    <= '0;
    end else begin
      w_state_reg <= w_state_next;
      wid_reg     <= wid_next;
      widx_reg    <= widx_next;
      wlen_reg    <= wlen_next;
      wcnt_reg    <= wcnt_next;
      werr_reg    <= werr_next;
      r_state_reg <= r_state_next;
      rid_reg     <= rid_next;
      ridx_reg    <= ridx_next;
      rlen_reg    <= rlen_next;
      rcnt_reg    <= rcnt_next;
    end
  end

  assign w_in_range  = 32'(widx_reg) < MEM_DEPTH;
  assign w_last_beat = (wcnt_reg == wlen_reg);

  always_comb begin
    w_state_next = w_state_reg;
    wid_next     = wid_reg;
    widx_next    = widx_reg;
    wlen_next    = wlen_reg;
    wcnt_next    = wcnt_reg;
    werr_next    = werr_reg;
    ram_we       = 1'b0;
    awready      = (w_state_reg == W_IDLE);
    wready       = (w_state_reg == W_DATA);
    bvalid       = (w_state_reg == W_RESP);
    case (w_state_reg)
      W_IDLE: if (awvalid) begin
        wid_next     = awid;
        widx_next    = awaddr[ADDR_WIDTH-1:OFF];
        wlen_next    = awlen;
        wcnt_next    = 8'd0;
        werr_next    = 1'b0;
        w_state_next = W_DATA;
      end
      // The beat count, not wlast, decides where the burst ends.
      W_DATA: if (wvalid) begin
        ram_we    = w_in_range;
        if (!w_in_range || (wlast != w_last_beat)) werr_next = 1'b1;
        widx_next = widx_reg + IDX_ONE;
        wcnt_next = wcnt_reg + 8'd1;
        if (w_last_beat) w_state_next = W_RESP;
      end
      W_RESP: if (bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  assign bid   = wid_reg;
  assign bresp = (bvalid && werr_reg) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    r_state_next  = r_state_reg;
    rid_next      = rid_reg;
    ridx_next     = ridx_reg;
    rlen_next     = rlen_reg;
    rcnt_next     = rcnt_reg;
    ram_re        = 1'b0;
    ram_raddr_idx = ridx_reg;
    arready       = (r_state_reg == R_IDLE);
    rvalid        = (r_state_reg == R_DATA);
    case (r_state_reg)
      R_IDLE: if (arvalid) begin
        rid_next      = arid;
        ridx_next     = araddr[ADDR_WIDTH-1:OFF];
        rlen_next     = arlen;
        rcnt_next     = 8'd0;
        ram_re        = 1'b1;
        ram_raddr_idx = araddr[ADDR_WIDTH-1:OFF];
        r_state_next  = R_DATA;
      end
      // Prefetch the next word on each handshake; the RAM output holds while stalled.
      R_DATA: if (rready) begin
        if (rcnt_reg == rlen_reg) begin
          r_state_next = R_IDLE;
        end else begin
          ridx_next     = ridx_reg + IDX_ONE;
          rcnt_next     = rcnt_reg + 8'd1;
          ram_re        = 1'b1;
          ram_raddr_idx = ridx_reg + IDX_ONE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign r_in_range = 32'(ridx_reg) < MEM_DEPTH;
  assign rid        = rid_reg;
  assign rlast      = rvalid && (rcnt_reg == rlen_reg);
  assign rresp      = (rvalid && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
  assign rdata      = (rvalid && r_in_range) ? ram_q : '0;

  axi_slave_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .RAM_AW    (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   ({STRB_W{ram_we}} & wstrb),
    .waddr(widx_reg[RAM_AW-1:0]),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(ram_raddr_idx[RAM_AW-1:0]),
    .rdata(ram_q)
  );

  logic unused_bits;
  assign unused_bits = ^{awaddr[OFF-1:0], araddr[OFF-1:0], ram_raddr_idx[IDX_W-1:RAM_AW]};

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
AXI4 slave memory that sits inside axi_top, directly downstream of the AXI master traffic generator, and terminates all five channels. It services single-outstanding INCR write and read bursts against an internal word-addressed RAM. Read and write paths are independent FSMs sharing the array. It is the target that tb_axi_basic exercises through axi_top.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, data bus width; only full-width beats are supported (size fixed at log2(DATA_WIDTH/8))
ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 1024, number of DATA_WIDTH words

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  beats minus one
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  beats minus one
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  read ID
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset (async, rst_n=0): both FSMs go to IDLE; awready=1, arready=1, all other outputs 0; RAM contents are not cleared. A reset mid-burst aborts it with no response.
- Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits are ignored. Bursts are always INCR; index increments by 1 per beat, with no 4 KB boundary check.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - awready=1 only in W_IDLE. The AW handshake latches awid, index and awlen, clears the beat counter and error flag, and moves to W_DATA.
  - wready=1 only in W_DATA. Each W handshake writes the bytes enabled by wstrb at the current index, then increments the index and counter.
  - Index >= MEM_DEPTH: no write; set error.
  - wlast != (counter==len): set error.
  - The burst ends on the beat where counter==len, regardless of wlast. Move to W_RESP with bvalid=1 the next cycle, bid=latched ID, bresp=SLVERR(2'b10) if error else OKAY(2'b00).
  - bvalid holds with stable outputs until bready, then return to W_IDLE; awready=1 the following cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - arready=1 only in R_IDLE. The AR handshake latches arid, index and arlen.
  - The first rvalid appears exactly 1 cycle after the AR handshake (registered RAM read).
  - Per beat: rdata=mem[index] with rresp=OKAY, or rdata=0 with rresp=SLVERR if index >= MEM_DEPTH. rlast=1 when counter==len.
  - R outputs hold stable while rvalid && !rready. On each handshake the next beat is presented the following cycle (back-to-back, 1 beat/cycle under constant rready).
  - After the rlast handshake, rvalid=0 and the FSM returns to R_IDLE.
- Concurrency: read and write proceed simultaneously. A read of a word written in the same cycle returns the pre-write data.
- awlen=0 and arlen=0 are single-beat bursts. awlen=255 gives 256 beats; the counter is 8 bits plus an end compare and does not overflow.

Decomposition:
- Shared package/header axi_defines: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encodings, default widths.
- One sub-module axi_slave_mem_ram: 1 write port with byte enables, 1 registered read port, depth MEM_DEPTH.
- Write and read FSMs live in axi_slave_mem.

Test Plan:
1. Single write awaddr=0x0010, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, then read same address -> bresp=OKAY, bid=awid; rdata=0xDEADBEEF, rlast=1, rresp=OKAY.
2. 4-beat INCR write at 0x0100 with data 1..4, then 4-beat read with rready toggling every cycle -> data 1,2,3,4 in order, stable while stalled, rlast only on beat 4.
3. Write wstrb=0x3 data 0x11223344 over a word holding 0xAAAAAAAA -> read returns 0xAAAA3344.
4. Write at 0x0FFC (index 1023) awlen=1 -> beat 1 written, beat 2 dropped, bresp=SLVERR; read same burst -> beat 1 OKAY, beat 2 rdata=0 SLVERR.
5. awlen=2 with wlast asserted on beat 2 -> burst still takes 3 beats, bresp=SLVERR; simultaneous independent read burst completes with OKAY.
6. Assert rst_n=0 mid write burst (after beat 1 of 4) -> no bvalid; awready=1 and arready=1 after release; a new transaction completes normally.
